// File: rtl/fifo_refill_pkg.sv
// Shared types and width helpers for the line-FIFO refill controller.
package fifo_refill_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_REQ   = 3'd1;
    localparam state_t ST_CAP   = 3'd2;
    localparam state_t ST_WR    = 3'd3;
    localparam state_t ST_GAP   = 3'd4;
    localparam state_t ST_DRAIN = 3'd5;
    localparam state_t ST_CLEAR = 3'd6;

    function automatic int count_w(input int frame_words);
        return $clog2(frame_words + 1);
    endfunction

    function automatic int beat_w(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

endpackage

// File: rtl/fifo_refill_ctrl_if.sv
// FIFO-side and memory-side signals of the refill controller; master = controller.
interface fifo_refill_ctrl_if #(
    parameter int DATA_WIDTH = 35,
    parameter int ADDR_WIDTH = 9,
    parameter int MEM_AW     = 23
);
    logic [ADDR_WIDTH-1:0] fifo_wrptr;
    logic [ADDR_WIDTH-1:0] fifo_rdptr;
    logic                  fifo_full;
    logic                  fifo_clear;
    logic                  fifo_wren;
    logic [DATA_WIDTH-1:0] fifo_din;
    logic                  mem_req;
    logic [MEM_AW-1:0]     mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic                  mem_rready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  fifo_wrptr, fifo_rdptr, fifo_full, mem_gnt, mem_rvalid, mem_rdata,
        output fifo_clear, fifo_wren, fifo_din, mem_req, mem_addr, mem_rready
    );

    modport slave (
        output fifo_wrptr, fifo_rdptr, fifo_full, mem_gnt, mem_rvalid, mem_rdata,
        input  fifo_clear, fifo_wren, fifo_din, mem_req, mem_addr, mem_rready
    );
endinterface

// File: rtl/fifo_wr_pulser.sv
// Holds one returned word and emits it as an isolated single-cycle wren pulse.
module fifo_wr_pulser #(
    parameter int DATA_WIDTH = 35
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cap_en,
    input  logic [DATA_WIDTH-1:0] cap_data,
    input  logic                  wr_req,
    input  logic                  fifo_full,
    output logic                  fifo_wren,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  wr_done
);
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  wren_last_q, wren_last_d;

    // The FIFO counts wren rising edges, so a pulse is never allowed to follow another.
    always_comb begin
        hold_d      = hold_q;
        if (cap_en) hold_d = cap_data;
        fifo_wren   = wr_req & ~fifo_full & ~wren_last_q;
        wren_last_d = fifo_wren;
        wr_done     = fifo_wren;
        fifo_din    = hold_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q      <= '0;
            wren_last_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            wren_last_q <= wren_last_d;
        end
    end
endmodule

// File: rtl/fifo_refill_ctrl.sv
// Keeps the display line FIFO topped up with fixed-length bursts from frame memory.
// Optional UNDERRUN_CNT_EN adds a saturating FIFO underrun counter.
module fifo_refill_ctrl
    import fifo_refill_pkg::*;
#(
    parameter int DATA_WIDTH  = 35,
    parameter int ADDR_WIDTH  = 9,
    parameter int MEM_AW      = 23,
    parameter int BURST_LEN   = 16,
    parameter int LOW_WM      = 128,
    parameter int FRAME_WORDS = 76800,
    parameter int FRAME_BASE  = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic frame_start,
    output logic busy,
`ifdef UNDERRUN_CNT_EN
    input  logic        fifo_empty,
    input  logic        fifo_rden,
    output logic [15:0] underrun_cnt,
`endif
    fifo_refill_ctrl_if.master bus
);
    localparam int          COUNT_W  = count_w(FRAME_WORDS);
    localparam int          BEAT_W   = beat_w(BURST_LEN);
    localparam logic [31:0] FIFO_CAP = 32'(2**ADDR_WIDTH - 1);

    state_t               state_q, state_d;
    logic [MEM_AW-1:0]    addr_q, addr_d;
    logic [COUNT_W-1:0]   words_q, words_d;
    logic [BEAT_W-1:0]    beats_q, beats_d, beats_after;
    logic [ADDR_WIDTH-1:0] level;
    logic [31:0]          lvl32;
    logic                 start_acc, hs, admit, cap_en, wr_done;

    assign level     = bus.fifo_wrptr - bus.fifo_rdptr;
    assign lvl32     = 32'(level);
    assign start_acc = frame_start & enable;
    assign hs        = bus.mem_rvalid & bus.mem_rready;
    assign admit     = enable & (words_q != '0) & (lvl32 < 32'(LOW_WM))
                     & ((FIFO_CAP - lvl32) >= 32'(BURST_LEN));
    // beats_q counts words still owed by memory; it drops when a word is accepted.
    assign beats_after = beats_q - BEAT_W'(hs);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        words_d = words_q;
        beats_d = beats_q;
        cap_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_acc)  state_d = ST_CLEAR;
                else if (admit) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (bus.mem_gnt) begin
                    beats_d = BEAT_W'(BURST_LEN);
                    state_d = start_acc ? ST_DRAIN : ST_CAP;
                end else if (start_acc) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CAP: begin
                beats_d = beats_after;
                cap_en  = hs;
                if (start_acc)  state_d = (beats_after != '0) ? ST_DRAIN : ST_CLEAR;
                else if (hs)    state_d = ST_WR;
            end
            ST_WR: begin
                if (start_acc)    state_d = (beats_q != '0) ? ST_DRAIN : ST_CLEAR;
                else if (wr_done) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (start_acc) begin
                    state_d = (beats_q != '0) ? ST_DRAIN : ST_CLEAR;
                end else if (beats_q == '0) begin
                    state_d = ST_IDLE;
                    addr_d  = addr_q + MEM_AW'(BURST_LEN);
                    words_d = words_q - COUNT_W'(BURST_LEN);
                end else begin
                    state_d = ST_CAP;
                end
            end
            ST_DRAIN: begin
                beats_d = beats_after;
                if (beats_after == '0) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                addr_d  = MEM_AW'(FRAME_BASE);
                words_d = COUNT_W'(FRAME_WORDS);
                // A restart landing on the clear cycle earns its own clear pulse.
                state_d = start_acc ? ST_CLEAR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= MEM_AW'(FRAME_BASE);
            words_q <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            beats_q <= beats_d;
        end
    end

    assign bus.mem_req    = (state_q == ST_REQ) & ~start_acc;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_rready = (state_q == ST_CAP) | (state_q == ST_DRAIN);
    assign bus.fifo_clear = (state_q == ST_CLEAR);
    assign busy           = (state_q != ST_IDLE);

    fifo_wr_pulser #(.DATA_WIDTH(DATA_WIDTH)) u_pulser (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap_en    (cap_en),
        .cap_data  (bus.mem_rdata),
        .wr_req    (state_q == ST_WR),
        .fifo_full (bus.fifo_full),
        .fifo_wren (bus.fifo_wren),
        .fifo_din  (bus.fifo_din),
        .wr_done   (wr_done)
    );

`ifdef UNDERRUN_CNT_EN
    logic [15:0] urun_q, urun_d;

    always_comb begin
        urun_d = urun_q;
        if (start_acc)                                    urun_d = '0;
        else if (fifo_rden & fifo_empty & (urun_q != 16'hFFFF)) urun_d = urun_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) urun_q <= '0;
        else        urun_q <= urun_d;
    end

    assign underrun_cnt = urun_q;
`endif
endmodule

// File: tb/tb_fifo_refill_ctrl.sv
// Directed bench for fifo_refill_ctrl: admission table plus FIFO/memory model sequences.
module tb_fifo_refill_ctrl;
    localparam int DW = 35, AW = 4, MAW = 23, BL = 4, LWM = 8, FW = 16, BASE = 'h100;

    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, frame_start = 1'b0;
    logic busy;
`ifdef UNDERRUN_CNT_EN
    logic fifo_empty = 1'b0, fifo_rden = 1'b0;
    logic [15:0] underrun_cnt;
`endif

    fifo_refill_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_AW(MAW)) bus ();

    fifo_refill_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_AW(MAW), .BURST_LEN(BL),
        .LOW_WM(LWM), .FRAME_WORDS(FW), .FRAME_BASE(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start), .busy(busy),
`ifdef UNDERRUN_CNT_EN
        .fifo_empty(fifo_empty), .fifo_rden(fifo_rden), .underrun_cnt(underrun_cnt),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [MAW-1:0] a);
        return {12'hA5C, a};
    endfunction

    // Model controls (written by main only)
    bit model_on = 0, mem_auto = 0, stream = 0, force_full = 0;
    int rd_total = 0;
    logic [AW-1:0] tbl_wp = '0, tbl_rp = '0;
    // Model state (written by model only)
    logic [AW-1:0] wp = '0, rp = '0, lv;
    int rd_done = 0, beats_rem = 0, bidx = 0, cyc = 0, wr_cnt = 0, clr_cnt = 0, rule_viol = 0;
    logic [MAW-1:0] baddr = '0, gaddr = '0;
    bit gnt_pend = 0, hs_pend = 0, wr_pend = 0, clr_pend = 0, wren_prev = 0;
    logic [DW-1:0] got[$];

    // FIFO pointer model and memory responder, stepped once per negedge.
    initial begin
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        bus.fifo_wrptr = '0; bus.fifo_rdptr = '0; bus.fifo_full = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!model_on) begin
                wp = tbl_wp; rp = tbl_rp;
            end else if (clr_pend) begin
                wp = '0; rp = '0;
            end else begin
                if (wr_pend) wp = wp + AW'(1);
                if (rd_done < rd_total && wp != rp) begin rp = rp + AW'(1); rd_done++; end
            end
            lv = wp - rp;
            bus.fifo_wrptr = wp; bus.fifo_rdptr = rp;
            bus.fifo_full  = force_full || (lv == AW'(15));
            if (hs_pend) begin bidx++; beats_rem--; end
            if (gnt_pend) begin beats_rem = BL; bidx = 0; baddr = gaddr; end
            bus.mem_gnt = 1'b0;
            if (mem_auto && beats_rem == 0 && !gnt_pend && bus.mem_req) begin
                bus.mem_gnt = 1'b1; gaddr = bus.mem_addr;
            end
            bus.mem_rvalid = (beats_rem > 0) && (stream || (cyc % 2 == 0));
            bus.mem_rdata  = (beats_rem > 0) ? mk(baddr + MAW'(bidx)) : '0;
            #1;
            hs_pend  = bus.mem_rvalid && bus.mem_rready;
            gnt_pend = bus.mem_gnt;
            wr_pend  = bus.fifo_wren;
            clr_pend = bus.fifo_clear;
            if (bus.fifo_wren) begin
                got.push_back(bus.fifo_din);
                wr_cnt++;
                if (wren_prev || bus.mem_rready) rule_viol++;
            end
            wren_prev = bus.fifo_wren;
            if (bus.fifo_clear) begin got.delete(); clr_cnt++; end
        end
    end

    task automatic cyc_n(input int n);
        repeat (n) begin @(negedge clk); #2; end
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1; cyc_n(1); frame_start = 1'b0;
    endtask

    task automatic wait_req(input int maxc, input string nm);
        int n = 0;
        while (!bus.mem_req && n < maxc) begin cyc_n(1); n++; end
        check(nm, bus.mem_req, 1);
    endtask

    typedef struct {
        logic          en;
        logic [AW-1:0] wr;
        logic [AW-1:0] rd;
        logic          exp_req;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int bad, base_wr, base_clr, n;
        vecs[0] = '{1'b1, 4'd0,  4'd0,  1'b1};  // empty
        vecs[1] = '{1'b1, 4'd7,  4'd0,  1'b1};  // level 7, just below watermark
        vecs[2] = '{1'b1, 4'd8,  4'd0,  1'b0};  // level 8, at watermark
        vecs[3] = '{1'b1, 4'd3,  4'd5,  1'b0};  // wrapped level 14
        vecs[4] = '{1'b1, 4'd5,  4'd3,  1'b1};  // level 2
        vecs[5] = '{1'b0, 4'd0,  4'd0,  1'b0};  // disabled
        vecs[6] = '{1'b1, 4'd0,  4'd1,  1'b0};  // level 15 (full)
        vecs[7] = '{1'b1, 4'd2,  4'd15, 1'b1};  // wrapped level 3
        vecs[8] = '{1'b1, 4'd12, 4'd13, 1'b0};  // wrapped level 15

        cyc_n(3);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_rready", bus.mem_rready, 0);
        check("rst_wren", bus.fifo_wren, 0);
        check("rst_clear", bus.fifo_clear, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", bus.mem_addr, BASE);
        check("rst_din", bus.fifo_din, 0);
        rst_n = 1'b1; enable = 1'b1;
        cyc_n(4);
        check("no_req_before_frame", bus.mem_req, 0);

        // Admission rule: each vector starts from a fresh clear
        for (int i = 0; i < 9; i++) begin
            enable = 1'b1;
            pulse_fs();
            check($sformatf("vec%0d_clear", i), bus.fifo_clear, 1);
            tbl_wp = vecs[i].wr; tbl_rp = vecs[i].rd; enable = vecs[i].en;
            cyc_n(2);
            check($sformatf("vec%0d_req", i), bus.mem_req, vecs[i].exp_req);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_req);
            check($sformatf("vec%0d_addr", i), bus.mem_addr, BASE);
        end

        // Sequence A: fill to watermark, top-up, end of frame
        enable = 1'b1; tbl_wp = '0; tbl_rp = '0;
        rst_n = 1'b0; cyc_n(2); rst_n = 1'b1; cyc_n(1);
        model_on = 1; mem_auto = 1; stream = 0;
        pulse_fs();
        wait_req(6, "a_first_req");
        check("a_first_addr", bus.mem_addr, BASE);
        cyc_n(80);
        check("a_fill_words", got.size(), 8);
        bad = 0;
        foreach (got[i]) if (got[i] !== mk(MAW'(BASE + i))) bad++;
        check("a_fill_order", bad, 0);
        check("a_addr_after_2", bus.mem_addr, BASE + 8);
        check("a_stop_at_wm", bus.mem_req, 0);
        lv = wp - rp;
        check("a_level_8", lv, 8);
        rd_total = 1;
        wait_req(4, "a_refill_req");
        cyc_n(60);
        check("a_words_12", got.size(), 12);
        check("a_addr_after_3", bus.mem_addr, BASE + 12);
        rd_total = 200;
        cyc_n(150);
        check("a_words_16", got.size(), 16);
        bad = 0;
        foreach (got[i]) if (got[i] !== mk(MAW'(BASE + i))) bad++;
        check("a_frame_order", bad, 0);
        check("a_addr_end", bus.mem_addr, BASE + 16);
        check("a_idle_busy", busy, 0);
        check("a_idle_req", bus.mem_req, 0);

        // Sequence B: frame_start after 2 of 4 beats
        pulse_fs();
        n = 0;
        while (got.size() < 2 && n < 60) begin cyc_n(1); n++; end
        check("b_two_words", got.size(), 2);
        base_wr = wr_cnt; base_clr = clr_cnt;
        pulse_fs();
        n = 0;
        while (clr_cnt == base_clr && n < 30) begin cyc_n(1); n++; end
        check("b_clear_seen", clr_cnt, base_clr + 1);
        check("b_drain_no_wren", wr_cnt, base_wr);
        check("b_drain_consumed", beats_rem, 0);
        wait_req(6, "b_restart_req");
        check("b_restart_addr", bus.mem_addr, BASE);
        n = 0;
        while (got.size() < 1 && n < 30) begin cyc_n(1); n++; end
        check("b_first_word", got[0], mk(MAW'(BASE)));

        // Sequence C: rvalid continuously high
        stream = 1;
        pulse_fs();
        cyc_n(120);
        check("c_words", got.size(), 16);
        bad = 0;
        foreach (got[i]) if (got[i] !== mk(MAW'(BASE + i))) bad++;
        check("c_order", bad, 0);
        check("c_pulse_rules", rule_viol, 0);

        // Sequence D: fifo_full stall in WR
        force_full = 1;
        pulse_fs();
        cyc_n(14);
        check("d_stall_words", got.size(), 0);
        check("d_stall_wren", bus.fifo_wren, 0);
        check("d_stall_busy", busy, 1);
        force_full = 0;
        cyc_n(60);
        bad = (got.size() < 4) ? 1 : 0;
        for (int i = 0; i < 4 && i < got.size(); i++) if (got[i] !== mk(MAW'(BASE + i))) bad++;
        check("d_release_order", bad, 0);

`ifdef UNDERRUN_CNT_EN
        fifo_rden = 1'b1; fifo_empty = 1'b1;
        cyc_n(3);
        fifo_rden = 1'b0; fifo_empty = 1'b0;
        cyc_n(1);
        check("urun_count", underrun_cnt, 3);
        pulse_fs();
        check("urun_clear", underrun_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/fifo_refill_ctrl.md
Name: fifo_refill_ctrl

Overview:
Single-clock controller that keeps the pixel line FIFO topped up from frame memory for the display path of the picture frame. It monitors FIFO occupancy from the FIFO's write and read pointers, issues fixed-length burst read requests to the memory port, and forwards returned words into the FIFO write port. On each frame start it clears the FIFO and restarts at the frame base address.

Parameters:
DATA_WIDTH, 35, FIFO/memory data word width
ADDR_WIDTH, 9, FIFO pointer width; usable capacity is 2**ADDR_WIDTH-1
MEM_AW, 23, memory word-address width
BURST_LEN, 16, words per memory burst (power of two)
LOW_WM, 128, refill threshold in words
FRAME_WORDS, 76800, words per frame; must be a multiple of BURST_LEN
FRAME_BASE, 0, memory word address of word 0 of the frame

Ports:
clk  in  1  single clock; drives both FIFO clock inputs
rst_n  in  1  synchronous, active-low reset
enable  in  1  permits new bursts and frame restarts
frame_start  in  1  one-cycle pulse at vsync
fifo_wrptr  in  ADDR_WIDTH  FIFO write pointer
fifo_rdptr  in  ADDR_WIDTH  FIFO read pointer
fifo_full  in  1  FIFO full flag
fifo_clear  out  1  one-cycle FIFO pointer clear
fifo_wren  out  1  FIFO write strobe (edge-counted by FIFO)
fifo_din  out  DATA_WIDTH  FIFO write data
mem_req  out  1  burst request, held until grant
mem_addr  out  MEM_AW  burst start address
mem_gnt  in  1  one-cycle grant for mem_req
mem_rvalid  in  1  return-data valid
mem_rready  out  1  controller can accept a return word
mem_rdata  in  DATA_WIDTH  return data
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, all outputs 0, mem_addr=FRAME_BASE, words_left=0, beats_left=0, hold register empty.
- level = (fifo_wrptr - fifo_rdptr) mod 2**ADDR_WIDTH; free = 2**ADDR_WIDTH-1-level.
- States: IDLE, REQ, CAP, WR, GAP, DRAIN, CLEAR.
- IDLE: enable & words_left!=0 & level<LOW_WM & free>=BURST_LEN -> REQ.
- REQ: mem_req=1 with mem_addr stable; on mem_gnt -> CAP, beats_left=BURST_LEN, mem_req drops the next cycle.
- CAP: mem_rready=1; on mem_rvalid capture mem_rdata into hold -> WR.
- WR: fifo_wren=1 for one cycle, fifo_din=hold; -> GAP.
- GAP: fifo_wren=0 for at least one cycle, because the FIFO counts only rising edges of wren. beats_left-1; if 0 -> IDLE with mem_addr+=BURST_LEN and words_left-=BURST_LEN, else -> CAP.
- mem_rready=0 in WR and GAP. The memory must hold the word while rready=0. Throughput is 1 word per 3 cycles.
- fifo_full seen in WR: stay in WR with wren low, and re-pulse when !fifo_full. The hold register is never overwritten. The admission rule normally prevents this.
- frame_start with enable=1 from any state: if a burst is granted and beats remain -> DRAIN, else -> CLEAR.
- DRAIN: mem_rready=1, remaining beats are discarded with no wren; at 0 -> CLEAR.
- A frame_start arriving during REQ withdraws mem_req immediately. If mem_gnt is seen the same cycle, the burst counts as granted.
- CLEAR: fifo_clear=1 for one cycle, mem_addr=FRAME_BASE, words_left=FRAME_WORDS -> IDLE.
- A frame_start arriving during DRAIN or CLEAR restarts the sequence; no second clear is lost.
- frame_start with enable=0 is ignored. Dropping enable mid-burst lets the burst finish; no new REQ is issued.
- words_left=0 (frame done): stay in IDLE until the next frame_start.
- mem_addr wraps modulo 2**MEM_AW.

Optional Feature:
UNDERRUN_CNT_EN
- Defined: adds inputs fifo_empty and fifo_rden, plus output underrun_cnt[15:0].
  - The counter increments on each cycle with fifo_rden & fifo_empty.
  - It saturates at 0xFFFF and clears on an accepted frame_start and on reset.
- Undefined: those ports and the counter do not exist; all other behaviour is identical.

Decomposition:
- Package fifo_refill_pkg: state enum, COUNT_W = clog2(FRAME_WORDS+1), BEAT_W = clog2(BURST_LEN+1).
- One natural sub-module, fifo_wr_pulser: owns the hold register and the WR/GAP pulse spacing, and handles fifo_full stall.

Test Plan (ADDR_WIDTH=4, BURST_LEN=4, LOW_WM=8, FRAME_WORDS=16, FRAME_BASE=0x100):
- Reset, enable=1, frame_start -> fifo_clear 1 cycle; mem_req with mem_addr=0x100. Grant, return beats A0..A3 -> 4 wren pulses, each followed by >=1 low cycle, fifo_din=A0..A3 in order; mem_addr becomes 0x104.
- No FIFO reads -> bursts until level=8, then no mem_req. Advance rdptr by 1 (level 7) -> mem_req within 2 cycles.
- 16 words written, FIFO drained to 0 -> no further mem_req, busy=0 until next frame_start.
- frame_start after 2 of 4 beats -> DRAIN accepts 2 beats with fifo_wren=0, then fifo_clear, then mem_req at 0x100.
- mem_rvalid held high every cycle with changing data -> mem_rready low in WR/GAP; FIFO receives every word exactly once, in order.
- UNDERRUN_CNT_EN: 3 cycles of fifo_rden with fifo_empty=1 -> underrun_cnt=3; frame_start -> 0.
